lu_rr_arbiter: RTL and testbench
================================

Name: lu_rr_arbiter

Overview:
- Shares one combinational logical unit among NREQ requesters (cores / pipeline ports) using round-robin arbitration.
- Drives the operand and function inputs of the shared unit, then registers its result with the winner's tag in a single-entry response buffer.
- Provides valid/ready handshakes on both the request side and the response side.
- Sits between the per-core execute stages and the shared logical unit in the multi-core datapath.

Parameters:
- N, 32, operand/result width; must be even.
- NREQ, 4, number of requesters; 2..8.
- TW, $clog2(NREQ), tag width; derived, never overridden.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  NREQ*N  operand a; requester k occupies bits [k*N +: N]
- req_b  in  NREQ*N  operand b; same packing as req_a
- req_af  in  NREQ*2  function select; requester k occupies bits [k*2 +: 2]
- req_i  in  NREQ  immediate flag per requester
- lu_a  out  N  operand a to shared unit
- lu_b  out  N  operand b to shared unit
- lu_af  out  2  function select to shared unit
- lu_i  out  1  immediate flag to shared unit
- lu_res  in  N  combinational result from shared unit
- rsp_valid  out  1  response buffer holds a result
- rsp_tag  out  TW  index of the requester that owns the result
- rsp_res  out  N  registered result
- rsp_ready  in  1  consumer accepts the response

Behaviour:
- Shared unit function:
  - af=00: a&b
  - af=01: a|b
  - af=10: a^b
  - af=11, i=0: ~(a|b)
  - af=11, i=1: {b[N/2-1:0], N/2 zeros}
- Arbitration state:
  - Round-robin pointer ptr (TW bits).
  - Response buffer {rsp_valid, rsp_tag, rsp_res}.
- can_accept = !rsp_valid || rsp_ready (buffer empty, or being drained this cycle).
- Grant (combinational):
  - When can_accept, gnt = first k with req_valid[k]=1, searching ptr, ptr+1, … modulo NREQ.
  - req_ready = one-hot(gnt) when can_accept and any req_valid; otherwise all zero.
  - req_ready must not depend on req_valid of non-winning requesters beyond the priority search.
- Operand mux:
  - lu_a/lu_b/lu_af/lu_i = winner's fields when a grant occurs.
  - Otherwise they hold requester ptr's fields, so there is no X-propagation.
- On handshake (req_valid[k] && req_ready[k]) at edge t:
  - rsp_res <= lu_res, rsp_tag <= k, rsp_valid <= 1.
  - ptr <= (k+1) mod NREQ.
  - Latency is exactly 1 cycle: result is visible the cycle after acceptance.
- Drain:
  - rsp_valid && rsp_ready with no new grant → rsp_valid <= 0 next edge.
  - Drain and grant in the same cycle → buffer reloads; rsp_valid stays 1 (full throughput, one op/cycle).
- Back-pressure:
  - rsp_valid && !rsp_ready → all req_ready = 0.
  - Buffer contents and ptr are held stable.
- ptr is unchanged in any cycle without a grant.
- Requesters must hold their fields stable while req_valid && !req_ready; the arbiter does not latch unaccepted requests.
- Reset (asynchronous, any time, including with the buffer full or back-pressured):
  - rsp_valid=0, rsp_tag=0, rsp_res=0, ptr=0.
  - req_ready is 0 while rst_n=0.
  - An in-flight response is discarded.
  - First grant after reset favours requester 0.
- Wrap-around: ptr = NREQ-1 and requester NREQ-1 granted → ptr becomes 0.
- No requests: rsp_valid drains normally, and ptr and the buffer are otherwise static.

Test Plan:
- Reset then single op:
  - Stimulus: req 2 valid, a=0xF0F0F0F0, b=0x0FF00FF0, af=01.
  - Expect: req_ready[2]=1 the same cycle; next cycle rsp_valid=1, tag=2, res=0xFFF0FFF0; ptr=3.
- All four requesters continuously valid, rsp_ready=1:
  - Expect grants 0,1,2,3,0,… one per cycle.
  - Expect tags to follow the same order and rsp_valid to stay high with no bubbles.
- Back-pressure:
  - Stimulus: rsp_ready=0 for 3 cycles with req 1 valid.
  - Expect: req_ready=0 throughout; rsp_res/tag held; on rsp_ready=1, req 1 is granted in that same cycle and the buffer reloads.
- Function coverage via requester 0, with b=0x0000ABCD:
  - af=10, a=0xFFFF0000 → 0xFFFFABCD.
  - af=11, i=0, a=0 → 0xFFFF5432.
  - af=11, i=1 → 0xABCD0000.
  - af=00, a=0x0000FF00 → 0x0000AB00.
- Wrap and skip:
  - Stimulus: ptr=3 with only req 1 valid.
  - Expect: grant 1, ptr=2; then with req 3 and req 1 both valid, grant 3, then 1.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges while rsp_valid=1 and back-pressured.
  - Expect: rsp_valid=0 immediately; after release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/lu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational logical unit among NREQ requesters.
// The winner's result and tag are captured in a single-entry response buffer.
module lu_rr_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    localparam int TW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*2-1:0] req_af,
    input  logic [NREQ-1:0]   req_i,
    output logic [N-1:0]      lu_a,
    output logic [N-1:0]      lu_b,
    output logic [1:0]        lu_af,
    output logic              lu_i,
    input  logic [N-1:0]      lu_res,
    output logic              rsp_valid,
    output logic [TW-1:0]     rsp_tag,
    output logic [N-1:0]      rsp_res,
    input  logic              rsp_ready
);

    logic [TW-1:0] ptr_q, ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [TW-1:0] rsp_tag_q, rsp_tag_d;
    logic [N-1:0]  rsp_res_q, rsp_res_d;

    logic          can_accept;
    logic          gnt_found;
    logic [TW-1:0] gnt_idx;
    logic [TW:0]   cand;
    logic [TW-1:0] sel;

    assign can_accept = !rsp_valid_q || rsp_ready;

    // Priority search starting at ptr; the extra bit in cand lets the sum wrap modulo NREQ
    // even when NREQ is not a power of two.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr_q} + (TW+1)'(off);
            if (cand >= (TW+1)'(NREQ)) begin
                cand = cand - (TW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[TW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[TW-1:0];
            end
        end
        if (!can_accept || !rst_n) begin
            gnt_found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_found) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    // Without a grant the unit still sees requester ptr's fields, never X.
    always_comb begin
        sel   = gnt_found ? gnt_idx : ptr_q;
        lu_a  = req_a[int'(sel)*N +: N];
        lu_b  = req_b[int'(sel)*N +: N];
        lu_af = req_af[int'(sel)*2 +: 2];
        lu_i  = req_i[sel];
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_res_d   = rsp_res_q;
        if (gnt_found) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = gnt_idx;
            rsp_res_d   = lu_res;
            ptr_d       = (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_res_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_res   = rsp_res_q;

endmodule

// File: tb/tb_lu_rr_arbiter.sv
// Bench for lu_rr_arbiter: vector table, directed corner sequences and random traffic
// checked against a queue-free round-robin reference model.
module tb_lu_rr_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int TW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ*2-1:0] req_af;
    logic [NREQ-1:0]   req_i;
    logic [N-1:0]      lu_a, lu_b, lu_res;
    logic [1:0]        lu_af;
    logic              lu_i;
    logic              rsp_valid;
    logic [TW-1:0]     rsp_tag;
    logic [N-1:0]      rsp_res;
    logic              rsp_ready;

    logic [N-1:0] ta [NREQ];
    logic [N-1:0] tbv[NREQ];
    logic [1:0]   taf[NREQ];
    logic         ti [NREQ];

    assign req_a  = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b  = {tbv[3], tbv[2], tbv[1], tbv[0]};
    assign req_af = {taf[3], taf[2], taf[1], taf[0]};
    assign req_i  = {ti[3], ti[2], ti[1], ti[0]};

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lu_fn(logic [N-1:0] a, logic [N-1:0] b,
                                           logic [1:0] af, logic i);
        case (af)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return i ? (b << (N/2)) : ~(a | b);
        endcase
    endfunction

    assign lu_res = lu_fn(lu_a, lu_b, lu_af, lu_i);

    lu_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_af(req_af), .req_i(req_i),
        .lu_a(lu_a), .lu_b(lu_b), .lu_af(lu_af), .lu_i(lu_i), .lu_res(lu_res),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_res(rsp_res),
        .rsp_ready(rsp_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int           m_ptr;
    bit           m_valid;
    int           m_tag;
    logic [N-1:0] m_res;
    int           last_gnt;
    logic [NREQ-1:0] seen_ready;

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = 0; m_res = '0;
    endtask

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic do_cycle();
        int g;
        int s;
        logic [NREQ-1:0] er;
        #1;
        g = -1;
        if (!m_valid || rsp_ready) begin
            for (int off = 0; off < NREQ; off++) begin
                int k;
                k = (m_ptr + off) % NREQ;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        seen_ready = req_ready;
        chk("req_ready", req_ready, er);
        s = (g >= 0) ? g : m_ptr;
        chk("lu_a", lu_a, ta[s]);
        chk("lu_b", lu_b, tbv[s]);
        chk("lu_af", lu_af, taf[s]);
        chk("lu_i", lu_i, ti[s]);
        last_gnt = g;
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1;
            m_tag   = g;
            m_res   = lu_fn(ta[g], tbv[g], taf[g], ti[g]);
            m_ptr   = (g + 1) % NREQ;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_tag", rsp_tag, m_tag);
        chk("rsp_res", rsp_res, m_res);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_res", rsp_res, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic set_req(int k, logic [N-1:0] a, logic [N-1:0] b, logic [1:0] af, logic i);
        ta[k] = a; tbv[k] = b; taf[k] = af; ti[k] = i;
    endtask

    typedef struct {
        logic [1:0]   af;
        logic         i;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2'b10, 1'b0, 32'hFFFF0000, 32'h0000ABCD, 32'hFFFFABCD};
        vecs[1] = '{2'b11, 1'b0, 32'h00000000, 32'h0000ABCD, 32'hFFFF5432};
        vecs[2] = '{2'b11, 1'b1, 32'h12345678, 32'h0000ABCD, 32'hABCD0000};
        vecs[3] = '{2'b00, 1'b0, 32'h0000FF00, 32'h0000ABCD, 32'h0000AB00};
        vecs[4] = '{2'b01, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};

        rst_n = 1'b1; rsp_ready = 1'b1; req_valid = '0;
        for (int k = 0; k < NREQ; k++) set_req(k, N'(k * 32'h11111111), N'(32'h0F0F0F0F), 2'(k), 1'b0);
        model_reset();
        do_reset();

        // Single op from requester 2
        set_req(2, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b01, 1'b0);
        req_valid = 4'b0100;
        do_cycle();
        chk("single_ready", seen_ready, 4'b0100);
        chk("single_tag", rsp_tag, 2);
        chk("single_res", rsp_res, 32'hFFF0FFF0);
        // ptr is now 3: with all valid, requester 3 wins
        req_valid = 4'b1111;
        do_cycle();
        chk("ptr3_ready", seen_ready, 4'b1000);

        // Wrap and skip: make ptr=3, then only req 1 valid
        req_valid = 4'b0100; do_cycle();
        req_valid = 4'b0010; do_cycle();
        chk("skip_ready", seen_ready, 4'b0010);
        req_valid = 4'b1010; do_cycle();
        chk("skip_3", seen_ready, 4'b1000);
        req_valid = 4'b0010; do_cycle();
        chk("skip_1", seen_ready, 4'b0010);

        // Back-pressure with buffer full (tag 1)
        set_req(1, 32'hAAAA5555, 32'h0000FFFF, 2'b10, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            do_cycle();
            chk("bp_ready", seen_ready, 4'b0000);
            chk("bp_tag", rsp_tag, 1);
            chk("bp_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        do_cycle();
        chk("bp_release", seen_ready, 4'b0010);
        chk("bp_reload", rsp_res, 32'hAAAAAAAA);
        req_valid = '0;
        do_cycle();
        chk("drain", rsp_valid, 0);

        // Function coverage through requester 0
        req_valid = 4'b0001;
        for (int v = 0; v < 5; v++) begin
            set_req(0, vecs[v].a, vecs[v].b, vecs[v].af, vecs[v].i);
            do_cycle();
            chk("func_tag", rsp_tag, 0);
            chk("func_res", rsp_res, vecs[v].exp_res);
        end
        req_valid = '0;
        do_cycle();

        // Round robin with everybody valid, no bubbles
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            do_cycle();
            chk("rr_tag", rsp_tag, c % NREQ);
            chk("rr_valid", rsp_valid, 1);
        end

        // Asynchronous reset while full and back-pressured
        rsp_ready = 1'b0;
        do_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_res", rsp_res, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        do_cycle();
        chk("arst_first", seen_ready, 4'b0010);

        // Random traffic; unaccepted requests keep their fields and valid
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!(req_valid[k] && last_gnt != k)) begin
                    req_valid[k] = ($urandom_range(0, 1) == 1);
                    set_req(k, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
            end
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
